// File: rtl/sha2_pkg.sv
// SHA-2 shared definitions: word/round constants, the schedule sequencer
// state encoding, and the bitwise helper functions used by both the message
// schedule (small sigmas) and the round unit (big sigmas, Ch, Maj).
package sha2_pkg;

  localparam int SHA256_WORD_W    = 32;
  localparam int SHA256_ROUNDS    = 64;
  localparam int SHA256_MSG_WORDS = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_EXPAND = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_WAIT   = ST_WAIT,
    S_LOAD   = ST_LOAD,
    S_EXPAND = ST_EXPAND,
    S_FIN    = ST_FIN
  } sched_state_e;

  function automatic logic [SHA256_WORD_W-1:0] ROTR_32(input logic [SHA256_WORD_W-1:0] x,
                                                       input int n);
    return (x >> n) | (x << (SHA256_WORD_W - n));
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] SHR(input logic [SHA256_WORD_W-1:0] x,
                                                   input int n);
    return x >> n;
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] sigma0_32(input logic [SHA256_WORD_W-1:0] x);
    return ROTR_32(x, 7) ^ ROTR_32(x, 18) ^ SHR(x, 3);
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] sigma1_32(input logic [SHA256_WORD_W-1:0] x);
    return ROTR_32(x, 17) ^ ROTR_32(x, 19) ^ SHR(x, 10);
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] big_sigma0_32(input logic [SHA256_WORD_W-1:0] x);
    return ROTR_32(x, 2) ^ ROTR_32(x, 13) ^ ROTR_32(x, 22);
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] big_sigma1_32(input logic [SHA256_WORD_W-1:0] x);
    return ROTR_32(x, 6) ^ ROTR_32(x, 11) ^ ROTR_32(x, 25);
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] ch_32(input logic [SHA256_WORD_W-1:0] x,
                                                     input logic [SHA256_WORD_W-1:0] y,
                                                     input logic [SHA256_WORD_W-1:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] maj_32(input logic [SHA256_WORD_W-1:0] x,
                                                      input logic [SHA256_WORD_W-1:0] y,
                                                      input logic [SHA256_WORD_W-1:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_window.sv
// Sixteen-word sliding window of the SHA-256 message schedule plus the
// combinational expansion of the next schedule word.
// Ports:
//   clk       clock
//   clr       synchronous clear of every window entry (wins over shift)
//   shift_en  shift the window by one word
//   load_sel  1: shift in load_data (message load), 0: shift in next_w
//   load_data incoming message word
//   next_w    W_t computed from the current window contents
module sha256_msg_window
  import sha2_pkg::*;
#(
  parameter int DATA_W = SHA256_WORD_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              load_sel,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] next_w
);

  // win[15] is W_{t-1}, win[0] is W_{t-16}
  logic [DATA_W-1:0] win [SHA256_MSG_WORDS];

  always_comb begin
    next_w = sigma1_32(win[14]) + win[9] + sigma0_32(win[1]) + win[0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < SHA256_MSG_WORDS; i++) win[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < SHA256_MSG_WORDS - 1; i++) win[i] <= win[i+1];
      win[SHA256_MSG_WORDS-1] <= load_sel ? load_data : next_w;
    end
  end

endmodule

// File: rtl/xunit_sha_msg_sched.sv
// SHA-256 message-schedule sequencer (Versat unit). Loads a 512-bit block as
// 16 serial words, then expands it, presenting one schedule word W_t per
// round with its index t for the K ROM and round unit.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   running, run      accelerator freeze control, one-cycle start pulse
//   done              idle or finished
//   delay0            cycles to wait after run before accepting words
//   msg_data/valid    message word input, msg_ready accepts it
//   w_out/w_valid     schedule word and its qualifier
//   round_idx         t of w_out; last_round flags t == ROUNDS-1
module xunit_sha_msg_sched
  import sha2_pkg::*;
#(
  parameter int DATA_W  = SHA256_WORD_W,
  parameter int DELAY_W = 32,
  parameter int ROUNDS  = SHA256_ROUNDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic               run,
  output logic               done,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [DATA_W-1:0]  msg_data,
  input  logic               msg_valid,
  output logic               msg_ready,
  output logic [DATA_W-1:0]  w_out,
  output logic               w_valid,
  output logic [5:0]         round_idx,
  output logic               last_round
);

  localparam logic [5:0] LAST_T      = 6'(ROUNDS - 1);
  localparam logic [5:0] LAST_LOAD_T = 6'(SHA256_MSG_WORDS - 1);

  sched_state_e       state, state_n;
  logic [DELAY_W-1:0] dcnt, dcnt_n;
  logic [5:0]         t, t_n, ridx, ridx_n;
  logic [DATA_W-1:0]  w_q, w_n, next_w;
  logic               wv_q, wv_n, last_q, last_n;
  logic               shift_en, load_sel, win_clr;

  sha256_msg_window #(.DATA_W(DATA_W)) u_window (
    .clk       (clk),
    .clr       (win_clr),
    .shift_en  (shift_en),
    .load_sel  (load_sel),
    .load_data (msg_data),
    .next_w    (next_w)
  );

  // run overrides everything, including a word offered in the same cycle,
  // so ready is withdrawn while run is high to keep the handshake honest
  assign msg_ready  = (state == S_LOAD) && running && !run;
  assign win_clr    = rst || run;
  assign done       = (state == S_IDLE) || (state == S_FIN);
  assign w_out      = w_q;
  assign round_idx  = ridx;
  // while frozen the registers hold, so the word is re-presented on resume
  assign w_valid    = wv_q && running;
  assign last_round = last_q && running;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      dcnt   <= '0;
      t      <= '0;
      ridx   <= '0;
      w_q    <= '0;
      wv_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state  <= state_n;
      dcnt   <= dcnt_n;
      t      <= t_n;
      ridx   <= ridx_n;
      w_q    <= w_n;
      wv_q   <= wv_n;
      last_q <= last_n;
    end
  end

  always_comb begin
    state_n  = state;
    dcnt_n   = dcnt;
    t_n      = t;
    ridx_n   = ridx;
    w_n      = w_q;
    wv_n     = wv_q;
    last_n   = last_q;
    shift_en = 1'b0;
    load_sel = 1'b0;
    if (run) begin
      // delay0 counts WAIT cycles; zero skips WAIT and loads immediately
      state_n = (delay0 == '0) ? S_LOAD : S_WAIT;
      dcnt_n  = delay0;
      t_n     = '0;
      ridx_n  = '0;
      w_n     = '0;
      wv_n    = 1'b0;
      last_n  = 1'b0;
    end else if (running) begin
      wv_n   = 1'b0;
      last_n = 1'b0;
      case (state)
        S_WAIT: begin
          dcnt_n = dcnt - 1'b1;
          if (dcnt <= DELAY_W'(1)) state_n = S_LOAD;
        end
        S_LOAD: begin
          if (msg_valid) begin
            shift_en = 1'b1;
            load_sel = 1'b1;
            w_n      = msg_data;
            wv_n     = 1'b1;
            ridx_n   = t;
            t_n      = t + 6'd1;
            if (t == LAST_LOAD_T) state_n = S_EXPAND;
          end
        end
        S_EXPAND: begin
          // the final word stays on the outputs one cycle before FIN,
          // so done rises the cycle after last_round
          if (last_q) begin
            state_n = S_FIN;
          end else begin
            shift_en = 1'b1;
            w_n      = next_w;
            wv_n     = 1'b1;
            ridx_n   = t;
            last_n   = (t == LAST_T);
            if (t != LAST_T) t_n = t + 6'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xunit_sha_msg_sched.sv
// Directed bench for the SHA-256 schedule sequencer: "abc" block, delay,
// bubbles, freeze, abort/restart and mid-block reset, plus a ROUNDS=17 build.
module tb_xunit_sha_msg_sched;

  localparam int ROUNDS   = 64;
  localparam int M_NORMAL = 0;
  localparam int M_BUBBLE = 1;
  localparam int M_FREEZE = 2;
  localparam int M_ABORT  = 3;
  localparam int M_RESET  = 4;

  logic        clk, rst, running, run, msg_valid;
  logic [31:0] delay0, msg_data;
  logic        done, msg_ready, w_valid, last_round;
  logic [31:0] w_out;
  logic [5:0]  round_idx;
  logic        done17, msg_ready17, w_valid17, last_round17;
  logic [31:0] w_out17;
  logic [5:0]  round_idx17;

  int errors = 0;
  int checks = 0;
  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];

  xunit_sha_msg_sched #(.DATA_W(32), .DELAY_W(32), .ROUNDS(64)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .done(done),
    .delay0(delay0), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .w_out(w_out), .w_valid(w_valid),
    .round_idx(round_idx), .last_round(last_round)
  );

  xunit_sha_msg_sched #(.DATA_W(32), .DELAY_W(32), .ROUNDS(17)) dut17 (
    .clk(clk), .rst(rst), .running(running), .run(run), .done(done17),
    .delay0(delay0), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_ready(msg_ready17), .w_out(w_out17), .w_valid(w_valid17),
    .round_idx(round_idx17), .last_round(last_round17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tbRotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] tbS0(input logic [31:0] x);
    return tbRotr(x, 7) ^ tbRotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] tbS1(input logic [31:0] x);
    return tbRotr(x, 17) ^ tbRotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d);
    msg_valid = v;
    msg_data  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Runs one block from run to completion (or to an abort/reset point),
  // checking every cycle against the expected schedule.
  task automatic runBlock(input int dly, input int mode, input bit do_run);
    int ne, wi, b3, b9, frz_left, cyc;
    bit acc_prev, frz, drop, ready_chk, finished, exp_valid;
    ne = 0; wi = 0; b3 = 0; b9 = 0; frz_left = 4; cyc = 0;
    acc_prev = 0; ready_chk = 0; finished = 0;
    if (do_run) begin
      run    = 1'b1;
      delay0 = 32'(dly);
      applyStimulus(1'b0, 32'h0);
      tick();
    end
    run = 1'b0;
    #1;
    checkOutput("done after run", 32'(done), 0);
    checkOutput("w_valid after run", 32'(w_valid), 0);
    for (int k = 0; k < dly; k++) begin
      checkOutput($sformatf("msg_ready wait cycle %0d", k + 1), 32'(msg_ready), 0);
      checkOutput($sformatf("done wait cycle %0d", k + 1), 32'(done), 0);
      tick();
      #1;
    end
    while (!finished && cyc < 200) begin
      cyc++;
      frz = (mode == M_FREEZE) && (ne == 31) && (frz_left > 0);
      running = !frz;
      drop = 1'b0;
      if (wi < 16) begin
        drop = (mode == M_BUBBLE) && ((wi == 3 && b3 < 2) || (wi == 9 && b9 < 2));
        applyStimulus(!drop, drop ? 32'h0 : blk[wi]);
      end else begin
        applyStimulus(1'b0, 32'h0);
      end
      if (mode == M_ABORT && ne == 40) run = 1'b1;
      if (mode == M_RESET && ne == 20) rst = 1'b1;
      #1;
      exp_valid = frz ? 1'b0 : ((ne < 16) ? acc_prev : 1'b1);
      checkOutput($sformatf("w_valid at t=%0d", ne), 32'(w_valid), 32'(exp_valid));
      if (mode == M_NORMAL && ne == 17) begin
        checkOutput("r17 done after last", 32'(done17), 1);
        checkOutput("r17 w_valid after last", 32'(w_valid17), 0);
      end
      if (frz) begin
        checkOutput("w_out frozen", w_out, exp_w[31]);
        checkOutput("round_idx frozen", 32'(round_idx), 31);
        checkOutput("msg_ready frozen", 32'(msg_ready), 0);
        frz_left--;
      end else if (exp_valid) begin
        checkOutput($sformatf("w_out t=%0d", ne), w_out, exp_w[ne]);
        checkOutput($sformatf("round_idx t=%0d", ne), 32'(round_idx), ne);
        checkOutput($sformatf("last_round t=%0d", ne), 32'(last_round),
                    (ne == ROUNDS - 1) ? 1 : 0);
        if (mode == M_NORMAL && ne == 16) begin
          checkOutput("r17 w_out t=16", w_out17, exp_w[16]);
          checkOutput("r17 round_idx", 32'(round_idx17), 16);
          checkOutput("r17 last_round", 32'(last_round17), 1);
        end
        ne++;
      end
      if (wi < 16) begin
        checkOutput($sformatf("msg_ready load word %0d", wi), 32'(msg_ready), 1);
        acc_prev = !drop;
        if (drop) begin
          if (wi == 3) b3++;
          else b9++;
        end else begin
          wi++;
        end
      end else begin
        acc_prev = 1'b0;
        if (!ready_chk) begin
          checkOutput("msg_ready after 16th", 32'(msg_ready), 0);
          ready_chk = 1'b1;
        end
      end
      if (run) begin
        tick();
        finished = 1'b1;
      end else if (rst) begin
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset w_out", w_out, 0);
        checkOutput("reset w_valid", 32'(w_valid), 0);
        checkOutput("reset round_idx", 32'(round_idx), 0);
        checkOutput("reset last_round", 32'(last_round), 0);
        checkOutput("reset msg_ready", 32'(msg_ready), 0);
        checkOutput("reset done", 32'(done), 1);
        finished = 1'b1;
      end else if (ne == ROUNDS) begin
        tick();
        #1;
        checkOutput("done after last", 32'(done), 1);
        checkOutput("w_valid after last", 32'(w_valid), 0);
        checkOutput("last_round after last", 32'(last_round), 0);
        finished = 1'b1;
      end else begin
        tick();
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout mode=%0d observed t=%0d required t=%0d", mode, ne, ROUNDS);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = tbS1(exp_w[i-2]) + exp_w[i-7] + tbS0(exp_w[i-15]) + exp_w[i-16];
    exp_w[16] = 32'h61626380;
    exp_w[17] = 32'h000F0000;

    rst = 1'b1; running = 1'b1; run = 1'b0; delay0 = 32'h0;
    applyStimulus(1'b0, 32'h0);
    tick();
    #1;
    checkOutput("init w_out", w_out, 0);
    checkOutput("init w_valid", 32'(w_valid), 0);
    checkOutput("init round_idx", 32'(round_idx), 0);
    checkOutput("init last_round", 32'(last_round), 0);
    checkOutput("init msg_ready", 32'(msg_ready), 0);
    checkOutput("init done", 32'(done), 1);
    rst = 1'b0;
    tick();

    $display("[TB] abc block");
    runBlock(0, M_NORMAL, 1'b1);
    $display("[TB] delay0=5");
    runBlock(5, M_NORMAL, 1'b1);
    $display("[TB] bubbles");
    runBlock(0, M_BUBBLE, 1'b1);
    $display("[TB] freeze");
    runBlock(0, M_FREEZE, 1'b1);
    $display("[TB] abort and restart");
    runBlock(0, M_ABORT, 1'b1);
    runBlock(0, M_NORMAL, 1'b0);
    $display("[TB] reset mid-block");
    runBlock(0, M_RESET, 1'b1);
    tick();
    #1;
    checkOutput("idle done", 32'(done), 1);
    checkOutput("idle w_valid", 32'(w_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
